// File: rtl/aes_seq_ctrl.sv
// Command sequencer for the AES core register port: writes config/key/block,
// polls status and returns the four result words over a valid/ready handshake.
//
// state  | meaning
// IDLE   | waiting for a command, cmd_ready high
// CFG    | write CONFIG with captured encdec/keylen
// KEY    | write KEY0..KEY7
// INIT   | write CTRL.init
// WAIT_K | idle cycles before polling for key expansion
// POLL_K | read STATUS until ready
// BLK    | write BLOCK0..BLOCK3
// NEXT   | write CTRL.next
// WAIT_V | idle cycles before polling for the result
// POLL_V | read STATUS until valid
// RES    | read RESULT0..RESULT3 into res_data
// DONE   | hold res_valid until res_ready
module aes_seq_ctrl #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int POLL_DELAY     = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_encdec,
  input  logic         cmd_keylen,
  input  logic         cmd_new_key,
  input  logic [255:0] cmd_key,
  input  logic [127:0] cmd_block,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [127:0] res_data,
  output logic         res_error,
  output logic         busy,
  output logic         aes_cs,
  output logic         aes_we,
  output logic [7:0]   aes_address,
  output logic [31:0]  aes_write_data,
  input  logic [31:0]  aes_read_data
);

  localparam int TMR_MAX = (TIMEOUT_CYCLES > POLL_DELAY) ? TIMEOUT_CYCLES : POLL_DELAY;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] TMO_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] DLY_LOAD = TMR_W'(POLL_DELAY - 1);

  localparam logic [7:0] ADDR_CTRL   = 8'h08;
  localparam logic [7:0] ADDR_STATUS = 8'h09;
  localparam logic [7:0] ADDR_CONFIG = 8'h0a;

  typedef enum logic [3:0] {
    S_IDLE, S_CFG, S_KEY, S_INIT, S_WAIT_K, S_POLL_K,
    S_BLK, S_NEXT, S_WAIT_V, S_POLL_V, S_RES, S_DONE
  } state_t;

  state_t             state_q, state_nxt;
  logic [2:0]         word_q, word_nxt;
  logic [TMR_W-1:0]   tmr_q, tmr_nxt;
  logic               enc_q, enc_nxt;
  logic               klen_q, klen_nxt;
  logic               new_key_q, new_key_nxt;
  logic [255:0]       key_q, key_nxt;
  logic [127:0]       blk_q, blk_nxt;
  logic               key_loaded_q, key_loaded_nxt;
  logic               loaded_klen_q, loaded_klen_nxt;
  logic [127:0]       res_data_nxt;
  logic               res_error_nxt;
  logic               cs_nxt, we_nxt;
  logic [7:0]         addr_nxt;
  logic [31:0]        wdata_nxt;
  logic               need_key;

  assign need_key = new_key_q | ~key_loaded_q | (klen_q != loaded_klen_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      word_q         <= '0;
      tmr_q          <= '0;
      enc_q          <= 1'b0;
      klen_q         <= 1'b0;
      new_key_q      <= 1'b0;
      key_q          <= '0;
      blk_q          <= '0;
      key_loaded_q   <= 1'b0;
      loaded_klen_q  <= 1'b0;
      cmd_ready      <= 1'b1;
      busy           <= 1'b0;
      res_valid      <= 1'b0;
      res_error      <= 1'b0;
      res_data       <= '0;
      aes_cs         <= 1'b0;
      aes_we         <= 1'b0;
      aes_address    <= '0;
      aes_write_data <= '0;
    end else begin
      state_q        <= state_nxt;
      word_q         <= word_nxt;
      tmr_q          <= tmr_nxt;
      enc_q          <= enc_nxt;
      klen_q         <= klen_nxt;
      new_key_q      <= new_key_nxt;
      key_q          <= key_nxt;
      blk_q          <= blk_nxt;
      key_loaded_q   <= key_loaded_nxt;
      loaded_klen_q  <= loaded_klen_nxt;
      cmd_ready      <= (state_nxt == S_IDLE);
      busy           <= (state_nxt != S_IDLE);
      res_valid      <= (state_nxt == S_DONE);
      res_error      <= res_error_nxt;
      res_data       <= res_data_nxt;
      aes_cs         <= cs_nxt;
      aes_we         <= we_nxt;
      aes_address    <= addr_nxt;
      aes_write_data <= wdata_nxt;
    end
  end

  always_comb begin
    state_nxt       = state_q;
    word_nxt        = '0;
    tmr_nxt         = tmr_q;
    enc_nxt         = enc_q;
    klen_nxt        = klen_q;
    new_key_nxt     = new_key_q;
    key_nxt         = key_q;
    blk_nxt         = blk_q;
    key_loaded_nxt  = key_loaded_q;
    loaded_klen_nxt = loaded_klen_q;
    res_data_nxt    = res_data;
    res_error_nxt   = res_error;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_nxt   = S_CFG;
          enc_nxt     = cmd_encdec;
          klen_nxt    = cmd_keylen;
          new_key_nxt = cmd_new_key;
          key_nxt     = cmd_key;
          blk_nxt     = cmd_block;
        end
      end
      S_CFG:  state_nxt = need_key ? S_KEY : S_BLK;
      S_KEY: begin
        if (word_q == 3'd7) state_nxt = S_INIT;
        else                word_nxt  = word_q + 3'd1;
      end
      S_INIT: begin
        state_nxt = S_WAIT_K;
        tmr_nxt   = DLY_LOAD;
      end
      S_WAIT_K: begin
        if (tmr_q == '0) begin
          state_nxt = S_POLL_K;
          tmr_nxt   = TMO_LOAD;
        end else begin
          tmr_nxt = tmr_q - 1'b1;
        end
      end
      S_POLL_K: begin
        if (aes_read_data[0]) begin
          state_nxt       = S_BLK;
          key_loaded_nxt  = 1'b1;
          loaded_klen_nxt = klen_q;
        end else if (tmr_q == '0) begin
          state_nxt      = S_DONE;
          res_error_nxt  = 1'b1;
          res_data_nxt   = '0;
          key_loaded_nxt = 1'b0;
        end else begin
          tmr_nxt = tmr_q - 1'b1;
        end
      end
      S_BLK: begin
        if (word_q == 3'd3) state_nxt = S_NEXT;
        else                word_nxt  = word_q + 3'd1;
      end
      S_NEXT: begin
        state_nxt = S_WAIT_V;
        tmr_nxt   = DLY_LOAD;
      end
      S_WAIT_V: begin
        if (tmr_q == '0) begin
          state_nxt = S_POLL_V;
          tmr_nxt   = TMO_LOAD;
        end else begin
          tmr_nxt = tmr_q - 1'b1;
        end
      end
      S_POLL_V: begin
        if (aes_read_data[1]) begin
          state_nxt = S_RES;
        end else if (tmr_q == '0) begin
          state_nxt      = S_DONE;
          res_error_nxt  = 1'b1;
          res_data_nxt   = '0;
          key_loaded_nxt = 1'b0;
        end else begin
          tmr_nxt = tmr_q - 1'b1;
        end
      end
      S_RES: begin
        res_data_nxt[{~word_q[1:0], 5'd0} +: 32] = aes_read_data;
        if (word_q == 3'd3) state_nxt = S_DONE;
        else                word_nxt  = word_q + 3'd1;
      end
      S_DONE: begin
        if (res_ready) begin
          state_nxt     = S_IDLE;
          res_error_nxt = 1'b0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bus outputs are registered, so they are decoded from the state being entered.
  always_comb begin
    cs_nxt    = 1'b0;
    we_nxt    = 1'b0;
    addr_nxt  = '0;
    wdata_nxt = '0;
    case (state_nxt)
      S_CFG: begin
        cs_nxt    = 1'b1;
        we_nxt    = 1'b1;
        addr_nxt  = ADDR_CONFIG;
        wdata_nxt = {30'b0, klen_nxt, enc_nxt};
      end
      S_KEY: begin
        cs_nxt    = 1'b1;
        we_nxt    = 1'b1;
        addr_nxt  = {5'b00010, word_nxt};
        wdata_nxt = key_q[{~word_nxt, 5'd0} +: 32];
      end
      S_INIT: begin
        cs_nxt    = 1'b1;
        we_nxt    = 1'b1;
        addr_nxt  = ADDR_CTRL;
        wdata_nxt = 32'h1;
      end
      S_POLL_K, S_POLL_V: begin
        cs_nxt   = 1'b1;
        addr_nxt = ADDR_STATUS;
      end
      S_BLK: begin
        cs_nxt    = 1'b1;
        we_nxt    = 1'b1;
        addr_nxt  = {6'b001000, word_nxt[1:0]};
        wdata_nxt = blk_q[{~word_nxt[1:0], 5'd0} +: 32];
      end
      S_NEXT: begin
        cs_nxt    = 1'b1;
        we_nxt    = 1'b1;
        addr_nxt  = ADDR_CTRL;
        wdata_nxt = 32'h2;
      end
      S_RES: begin
        cs_nxt   = 1'b1;
        addr_nxt = {6'b001100, word_nxt[1:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_aes_seq_ctrl.sv
// Bench for aes_seq_ctrl: behavioural AES core with a known-answer table,
// access-trace monitor and a result scoreboard.
module tb_aes_seq_ctrl;

  localparam int TMO = 16;
  localparam int DLY = 2;
  localparam int LAT = 6;

  localparam logic [127:0] K128  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic         clk, reset_n;
  logic         cmd_valid, cmd_ready, cmd_encdec, cmd_keylen, cmd_new_key;
  logic [255:0] cmd_key;
  logic [127:0] cmd_block;
  logic         res_valid, res_ready, res_error, busy;
  logic [127:0] res_data;
  logic         aes_cs, aes_we;
  logic [7:0]   aes_address;
  logic [31:0]  aes_write_data, aes_read_data;

  aes_seq_ctrl #(.TIMEOUT_CYCLES(TMO), .POLL_DELAY(DLY)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_encdec(cmd_encdec),
    .cmd_keylen(cmd_keylen), .cmd_new_key(cmd_new_key), .cmd_key(cmd_key),
    .cmd_block(cmd_block), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_error(res_error), .busy(busy),
    .aes_cs(aes_cs), .aes_we(aes_we), .aes_address(aes_address),
    .aes_write_data(aes_write_data), .aes_read_data(aes_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- AES core model ----------------
  function automatic logic [127:0] aes_ref(input logic [255:0] k, input logic kl,
                                           input logic enc, input logic [127:0] b);
    if (!kl && k[255:128] == K128 && enc && b == PT)     return CT128;
    if (!kl && k[255:128] == K128 && !enc && b == CT128) return PT;
    if (kl && k == K256 && enc && b == PT)               return CT256;
    return b ^ {4{32'hdeadbeef}};
  endfunction

  logic [31:0]  m_key [8];
  logic [31:0]  m_blk [4];
  logic         m_enc, m_klen, m_xklen, m_rdy, m_vld, m_op_next;
  logic [255:0] m_xkey;
  logic [127:0] m_res;
  int           m_cnt;
  bit           stuck = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) m_key[i] <= '0;
      for (int i = 0; i < 4; i++) m_blk[i] <= '0;
      m_enc <= 0; m_klen <= 0; m_xklen <= 0; m_rdy <= 1; m_vld <= 0;
      m_op_next <= 0; m_xkey <= '0; m_res <= '0; m_cnt <= 0;
    end else begin
      if (m_cnt > 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          if (m_op_next) begin
            m_res <= aes_ref(m_xkey, m_xklen, m_enc, {m_blk[0], m_blk[1], m_blk[2], m_blk[3]});
            m_vld <= 1'b1;
          end else begin
            m_xkey  <= {m_key[0], m_key[1], m_key[2], m_key[3],
                        m_key[4], m_key[5], m_key[6], m_key[7]};
            m_xklen <= m_klen;
          end
          m_rdy <= 1'b1;
        end
      end
      if (aes_cs && aes_we) begin
        if (aes_address == 8'h08) begin
          if (aes_write_data[0]) begin
            m_rdy <= 0; m_cnt <= LAT; m_op_next <= 0;
          end else if (aes_write_data[1]) begin
            m_rdy <= 0; m_vld <= 0; m_cnt <= LAT; m_op_next <= 1;
          end
        end else if (aes_address == 8'h0a) begin
          m_enc <= aes_write_data[0]; m_klen <= aes_write_data[1];
        end else if (aes_address[7:3] == 5'b00010) begin
          m_key[aes_address[2:0]] <= aes_write_data;
        end else if (aes_address[7:2] == 6'b001000) begin
          m_blk[aes_address[1:0]] <= aes_write_data;
        end
      end
    end
  end

  always_comb begin
    aes_read_data = 32'h0bad0bad;
    if (aes_cs && !aes_we) begin
      case (aes_address)
        8'h09:   aes_read_data = stuck ? 32'h0 : {30'b0, m_vld, m_rdy};
        8'h30:   aes_read_data = m_res[127:96];
        8'h31:   aes_read_data = m_res[95:64];
        8'h32:   aes_read_data = m_res[63:32];
        8'h33:   aes_read_data = m_res[31:0];
        default: aes_read_data = 32'h0bad0bad;
      endcase
    end
  end

  // ---------------- access monitor ----------------
  int n_cfg, n_key, n_init, n_blk, n_next, n_stat, n_res, n_busy, n_bad;
  int wd_viol = 0;
  logic [31:0]  cfg_data;
  logic [255:0] cur_key;
  logic [127:0] cur_blk;

  task automatic clear_trace();
    n_cfg = 0; n_key = 0; n_init = 0; n_blk = 0; n_next = 0;
    n_stat = 0; n_res = 0; n_busy = 0; n_bad = 0; cfg_data = '0;
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (busy && !res_valid) n_busy++;
      if (!(aes_cs && aes_we) && aes_write_data != 32'h0) wd_viol++;
      if (aes_cs && aes_we) begin
        if (aes_address == 8'h0a) begin
          n_cfg++; cfg_data = aes_write_data;
        end else if (aes_address == 8'h08) begin
          if (aes_write_data == 32'h1)      n_init++;
          else if (aes_write_data == 32'h2) n_next++;
          else                              n_bad++;
        end else if (aes_address[7:3] == 5'b00010) begin
          if (n_key > 7 || aes_address[2:0] != n_key[2:0] ||
              aes_write_data != cur_key[255 - 32*n_key -: 32]) n_bad++;
          n_key++;
        end else if (aes_address[7:2] == 6'b001000) begin
          if (n_blk > 3 || aes_address[1:0] != n_blk[1:0] ||
              aes_write_data != cur_blk[127 - 32*n_blk -: 32]) n_bad++;
          n_blk++;
        end else begin
          n_bad++;
        end
      end else if (aes_cs) begin
        if (aes_address == 8'h09) n_stat++;
        else if (aes_address[7:2] == 6'b001100 && aes_address[1:0] == n_res[1:0]) n_res++;
        else n_bad++;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [127:0] d;
    logic         e;
    logic         kl;
    logic         klen;
    logic         enc;
  } exp_t;
  exp_t sb[$];

  task automatic run_cmd(input logic enc, input logic kl, input logic nk,
                         input logic [255:0] key, input logic [127:0] blk,
                         input logic [127:0] exp_d, input logic exp_e,
                         input logic exp_kload, input int hold, input string tag);
    exp_t e;
    int   t;
    logic stable;
    logic [127:0] snap;
    @(negedge clk);
    cmd_valid = 1; cmd_encdec = enc; cmd_keylen = kl; cmd_new_key = nk;
    cmd_key = key; cmd_block = blk;
    cur_key = key; cur_blk = blk;
    t = 0;
    while (!cmd_ready && t < 100) begin @(negedge clk); t++; end
    if (!cmd_ready) begin
      chk({tag, "_handshake"}, cmd_ready, 1'b1);
      cmd_valid = 0;
      return;
    end
    clear_trace();
    sb.push_back('{d: exp_d, e: exp_e, kl: exp_kload, klen: kl, enc: enc});
    @(negedge clk);
    cmd_valid = 0; cmd_encdec = ~enc; cmd_keylen = ~kl; cmd_new_key = ~nk;
    cmd_key = ~key; cmd_block = ~blk;
    t = 0;
    while (!res_valid && t < 400) begin @(negedge clk); t++; end
    e = sb.pop_front();
    if (!res_valid) begin
      chk({tag, "_res_valid_timeout"}, res_valid, 1'b1);
      return;
    end
    if (hold > 0) begin
      snap = res_data; stable = 1;
      repeat (hold) begin
        @(negedge clk);
        if (res_data !== snap || cmd_ready || aes_cs || !res_valid) stable = 0;
      end
      chk({tag, "_backpressure_hold"}, stable, 1'b1);
    end
    chk({tag, "_data"}, res_data, e.d);
    chk({tag, "_error"}, res_error, e.e);
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
    chk({tag, "_idle_after_accept"}, {cmd_ready, busy, res_valid}, 3'b100);
    if (!e.e) begin
      chk({tag, "_key_writes"}, n_key, e.kl ? 8 : 0);
      chk({tag, "_init_writes"}, n_init, e.kl ? 1 : 0);
      chk({tag, "_cfg"}, {n_cfg[7:0], cfg_data}, {8'd1, 30'b0, e.klen, e.enc});
      chk({tag, "_blk_next_res"}, {n_blk[7:0], n_next[7:0], n_res[7:0]}, {8'd4, 8'd1, 8'd4});
      chk({tag, "_order"}, n_bad, 0);
      chk({tag, "_busy_cycles"}, n_busy, (e.kl ? 23 : 12) + n_stat);
    end else begin
      chk({tag, "_poll_reads"}, n_stat, TMO);
    end
  endtask

  initial begin
    int  t;
    bit  seen;
    reset_n = 0; cmd_valid = 0; cmd_encdec = 0; cmd_keylen = 0; cmd_new_key = 0;
    cmd_key = '0; cmd_block = '0; res_ready = 0;
    cur_key = '0; cur_blk = '0;
    clear_trace();
    repeat (3) @(negedge clk);
    chk("reset_flags", {cmd_ready, busy, res_valid, res_error, aes_cs, aes_we}, 6'b100000);
    chk("reset_bus", {aes_address, aes_write_data}, 40'h0);
    chk("reset_res_data", res_data, 128'h0);
    reset_n = 1;

    run_cmd(1, 0, 1, {K128, 128'h0}, PT, CT128, 0, 1, 0, "enc128");
    run_cmd(0, 0, 0, {K128, 128'h0}, CT128, PT, 0, 0, 50, "dec128");
    run_cmd(1, 1, 0, K256, PT, CT256, 0, 1, 3, "enc256");

    stuck = 1;
    run_cmd(1, 1, 0, K256, PT, 128'h0, 1, 0, 2, "timeout");
    stuck = 0;
    run_cmd(1, 1, 0, K256, PT, CT256, 0, 1, 0, "after_timeout");

    // abort in the middle of the key load
    @(negedge clk);
    cmd_valid = 1; cmd_encdec = 1; cmd_keylen = 0; cmd_new_key = 1;
    cmd_key = {K128, 128'h0}; cmd_block = PT;
    @(negedge clk);
    cmd_valid = 0;
    seen = 0; t = 0;
    while (!seen && t < 50) begin
      if (aes_cs && aes_we && aes_address == 8'h14) seen = 1;
      else begin @(negedge clk); t++; end
    end
    chk("rst_key_word4_seen", seen, 1'b1);
    reset_n = 0;
    #1;
    chk("rst_outputs_drop", {aes_cs, aes_we, busy, res_valid, cmd_ready}, 5'b00001);
    repeat (3) @(negedge clk);
    chk("rst_no_access", {aes_cs, aes_address, aes_write_data}, 41'h0);
    reset_n = 1;
    run_cmd(1, 0, 0, {K128, 128'h0}, PT, CT128, 0, 1, 0, "after_reset");

    chk("write_data_zero_when_idle", wd_viol, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/aes_seq_ctrl.md
# aes_seq_ctrl

Sequencer in front of the AES core's 8-bit-address register port. It accepts one command (key, block, mode) over a valid/ready handshake and drives the core's register writes: config, key, init, block and next. It polls status and reads the four result words back, returning a 128-bit result over a second valid/ready handshake. It sits between the Wishbone-facing user project logic and the `aes` instance, so firmware no longer has to bit-bang the core register by register.

## Interface
- `TIMEOUT_CYCLES`, 1024: maximum cycles spent in either poll state before aborting with `res_error`.
- `POLL_DELAY`, 2: cycles between a ctrl write and the first status read.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_encdec` in 1: 1 = encrypt, 0 = decrypt.
- `cmd_keylen` in 1: 0 = 128-bit key in `cmd_key[255:128]`, 1 = 256-bit key.
- `cmd_new_key` in 1: force key reload and key expansion.
- `cmd_key` in 256: key, MSW first.
- `cmd_block` in 128: input block, MSW first.
- `res_valid` out 1: result present.
- `res_ready` in 1: consumer accepts the result.
- `res_data` out 128: result, MSW first.
- `res_error` out 1: qualifies `res_valid`; a timeout occurred.
- `busy` out 1: not IDLE.
- `aes_cs` out 1: core chip select.
- `aes_we` out 1: core write enable.
- `aes_address` out 8: core register address.
- `aes_write_data` out 32: core write data.
- `aes_read_data` in 32: core read data, combinational in the same cycle as `aes_cs && !aes_we`.

## Operation
- Core map:
  - CTRL 0x08: bit0 init, bit1 next.
  - STATUS 0x09: bit0 ready, bit1 valid.
  - CONFIG 0x0a: bit0 encdec, bit1 keylen.
  - KEY0..7 0x10–0x17: 0x10 = `key[255:224]`.
  - BLOCK0..3 0x20–0x23: 0x20 = `block[127:96]`.
  - RESULT0..3 0x30–0x33: 0x30 = `result[127:96]`.
- Command capture: on `cmd_valid && cmd_ready`, the command is registered. Inputs are ignored until the next IDLE.
- One core access per cycle in every state except IDLE, WAIT_* and DONE, where `aes_cs = 0`.
- States and transitions:
  - IDLE: on handshake → CFG.
  - CFG: write CONFIG = {30'b0, keylen, encdec}. Then → KEY if `cmd_new_key`, or `key_loaded == 0`, or keylen differs from the last loaded keylen; else → BLK.
  - KEY: 8 writes, 0x10..0x17, word counter 0..7. Always writes all 8 words → INIT.
  - INIT: write CTRL = 0x1 → WAIT_K.
  - WAIT_K: `POLL_DELAY` idle cycles → POLL_K.
  - POLL_K: read STATUS each cycle. If bit0 = 1: set `key_loaded`, store keylen → BLK.
  - BLK: 4 writes, 0x20..0x23 → NEXT.
  - NEXT: write CTRL = 0x2 → WAIT_V.
  - WAIT_V: `POLL_DELAY` idle cycles → POLL_V.
  - POLL_V: read STATUS. If bit1 = 1 → RES.
  - RES: 4 reads, 0x30..0x33, each captured into `res_data` at that cycle's edge → DONE.
  - DONE: `res_valid = 1`. Hold all outputs until `res_ready`, then → IDLE.
- Timeout: a counter runs in POLL_K/POLL_V. When it reaches `TIMEOUT_CYCLES` → DONE with `res_error = 1`, `res_data = 0`, and `key_loaded` cleared.
- Unused write data bits are driven as 0. `aes_write_data = 0` when not writing.

## Timing
- Reset values (asynchronous):
  - state IDLE, `cmd_ready = 1`, `busy = 0`.
  - `res_valid = 0`, `res_error = 0`, `res_data = 0`.
  - `aes_cs = 0`, `aes_we = 0`, `aes_address = 0`, `aes_write_data = 0`.
  - `key_loaded = 0`, counters 0.
- All outputs are registered.
- Mid-operation reset: outputs drop immediately; no further core access. The core is reset by the same `reset_n` externally.
- Handshake cycle is T. CFG write is at T+1.
- Fixed overhead (cycles issuing accesses or waiting, excluding poll reads):
  - With key load: 1 + 8 + 1 + `POLL_DELAY` + 4 + 1 + `POLL_DELAY` + 4 = 23 at defaults, plus the poll reads.
  - Without key load: 1 + 4 + 1 + `POLL_DELAY` + 4 = 12, plus the poll reads.
- `res_valid` rises the cycle after the last RESULT read.
- `res_valid` and `res_data` are stable until accepted. `res_ready` while `res_valid = 0` is ignored.
- `cmd_ready` returns high the cycle after the result is accepted. A new command may be taken that same cycle. No back-to-back overlap.

## Test plan
- AES-128 encrypt, new key:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f in `[255:128]`, block 00112233445566778899aabbccddeeff.
  - Response: `res_data` = 69c4e0d86a7b0430d8cdb78070b4c55a, `res_error = 0`, access trace CFG, 8 KEY, INIT, polls, 4 BLK, NEXT, polls, 4 RES.
- Same key, `cmd_new_key = 0`, decrypt 69c4e0d86a7b0430d8cdb78070b4c55a:
  - Response: 00112233445566778899aabbccddeeff.
  - No writes to 0x10–0x17 and no CTRL = 0x1 write.
- AES-256 encrypt:
  - Stimulus: key 000102…1e1f, same block, `cmd_new_key = 0`.
  - Response: key reload is forced by the keylen change; `res_data` = 8ea2b7ca516745bfeafc49904b496089.
- Backpressure:
  - Stimulus: hold `res_ready = 0` for 50 cycles after `res_valid`.
  - Response: `res_data` unchanged, `cmd_ready = 0`, no core accesses.
  - Then pulse `res_ready` → IDLE next cycle.
- Timeout:
  - Stimulus: replace the core with a model whose STATUS always reads 0, `TIMEOUT_CYCLES = 16`.
  - Response: `res_valid` with `res_error = 1`, `res_data = 0`.
  - The next command reloads the key even with `cmd_new_key = 0`.
- Reset mid-KEY:
  - Stimulus: assert `reset_n = 0` at word 4.
  - Response: `aes_cs` is low before the next edge, `busy = 0`.
  - After release, a new command performs a full key load.
